eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Round-robin merge of several AXI-Stream TX sources into one MAC stream, frame-atomic,
// with forced abort (tlast+tuser) of frames that exceed MAX_FRAME_BEATS and drop of the remainder.
//
//   state | meaning
//   IDLE  | no frame in flight; pick next requesting channel after last_grant
//   PASS  | granted channel wired straight through to the MAC
//   DROP  | frame was aborted; swallow source beats up to and including its tlast
module eth_tx_arbiter #(
  parameter int NUM_CHANNELS    = 2,
  parameter int DATA_BITS       = 64,
  parameter int MAX_FRAME_BEATS = 190
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic [NUM_CHANNELS*DATA_BITS-1:0] s_axis_tdata,
  input  logic [NUM_CHANNELS*DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]           s_axis_tlast,
  input  logic [NUM_CHANNELS-1:0]           s_axis_tuser,
  input  logic [NUM_CHANNELS-1:0]           s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]           s_axis_tready,
  output logic [DATA_BITS-1:0]              m_axis_tdata,
  output logic [DATA_BITS/8-1:0]            m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] active_channel,
  output logic [NUM_CHANNELS*32-1:0]        frame_count,
  output logic [15:0]                       abort_count
);

  localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BEAT_BITS = $clog2(MAX_FRAME_BEATS + 1);
  localparam int KEEP_BITS = DATA_BITS / 8;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t               state;
  logic [CH_BITS-1:0]   grant;
  logic [CH_BITS-1:0]   last_grant;
  logic [CH_BITS-1:0]   next_grant;
  logic                 any_valid;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic [31:0]          frame_cnt [NUM_CHANNELS];

  logic [DATA_BITS-1:0] sel_data;
  logic [KEEP_BITS-1:0] sel_keep;
  logic                 sel_last;
  logic                 sel_user;
  logic                 sel_valid;
  logic                 force_abort;
  logic                 accept;
  logic                 drop_done;

  // Source mux keyed on grant; compare-based so NUM_CHANNELS need not be a power of two.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant == CH_BITS'(i)) begin
        sel_data  = s_axis_tdata[i*DATA_BITS +: DATA_BITS];
        sel_keep  = s_axis_tkeep[i*KEEP_BITS +: KEEP_BITS];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
        sel_valid = s_axis_tvalid[i];
      end
    end
  end

  // First requester at distance 1..NUM_CHANNELS above last_grant, wrapping.
  always_comb begin
    next_grant = '0;
    any_valid  = 1'b0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (!any_valid && s_axis_tvalid[i] &&
            (i == (int'(last_grant) + k) % NUM_CHANNELS)) begin
          any_valid  = 1'b1;
          next_grant = CH_BITS'(i);
        end
      end
    end
  end

  assign force_abort = (state == PASS) &&
                       (beat_cnt == BEAT_BITS'(MAX_FRAME_BEATS - 1)) && !sel_last;

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = sel_data;
    m_axis_tkeep  = sel_keep;
    m_axis_tlast  = sel_last | force_abort;
    m_axis_tuser  = sel_user | force_abort;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (grant == CH_BITS'(i)) begin
        if (state == PASS) s_axis_tready[i] = m_axis_tready;
        if (state == DROP) s_axis_tready[i] = 1'b1;
      end
    end
    if (state == PASS) m_axis_tvalid = sel_valid;
  end

  assign accept    = m_axis_tvalid & m_axis_tready;
  assign drop_done = (state == DROP) && sel_valid && sel_last;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= CH_BITS'(NUM_CHANNELS - 1);
      beat_cnt    <= '0;
      abort_count <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) frame_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant    <= next_grant;
            beat_cnt <= '0;
            state    <= PASS;
          end
        end
        PASS: begin
          if (accept) begin
            if (sel_last) begin
              last_grant <= grant;
              state      <= IDLE;
            end else if (force_abort) begin
              state <= DROP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DROP: begin
          if (drop_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (accept && force_abort && (abort_count != 16'hFFFF))
        abort_count <= abort_count + 16'd1;

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (accept && m_axis_tlast && (grant == CH_BITS'(i)))
          frame_cnt[i] <= frame_cnt[i] + 32'd1;
      end
    end
  end

  assign active_channel = grant;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_fc
    assign frame_count[g*32 +: 32] = frame_cnt[g];
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: queue-driven random sources and MAC backpressure,
// checked against a frame-level model (truncate at MAX_FRAME_BEATS, round-robin order).
module tb_eth_tx_arbiter;

  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int KW   = DW / 8;
  localparam int MAXB = 4;
  localparam int CHB  = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              resetn;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH*KW-1:0] s_tkeep;
  logic [NCH-1:0]    s_tlast, s_tuser, s_tvalid, s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast, m_tuser, m_tvalid, m_tready;
  logic [CHB-1:0]    active_channel;
  logic [NCH*32-1:0] frame_count;
  logic [15:0]       abort_count;

  eth_tx_arbiter #(.NUM_CHANNELS(NCH), .DATA_BITS(DW), .MAX_FRAME_BEATS(MAXB)) dut (
    .clock(clock), .resetn(resetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .active_channel(active_channel), .frame_count(frame_count), .abort_count(abort_count)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  beat_t src_q [NCH][$];
  beat_t exp_q [NCH][$];
  beat_t out_q [$];
  int    out_cyc [$];
  int    exp_frames [NCH];
  int    consumed [NCH];
  int    pushed [NCH];
  int    exp_aborts;
  bit    hold [NCH];
  bit    acc [NCH];
  bit    src_en;
  int    valid_pct, ready_pct;
  int    cyc, frame_id;
  int    mirror_err, active_err;
  logic [NCH-1:0] ready_seen;
  int    n_checks, n_fail;

  // Model: a frame longer than MAXB leaves as MAXB beats, the last flagged tlast+tuser.
  function automatic void enqueue_frame(int ch, int len, int user_pct);
    beat_t b;
    bit done = 1'b0;
    frame_id++;
    for (int k = 0; k < len; k++) begin
      b.data = {8'(ch), 8'(frame_id), 8'(k), 8'($urandom)};
      b.keep = 4'($urandom_range(1, 15));
      b.last = (k == len - 1);
      b.user = ($urandom_range(0, 99) < user_pct);
      src_q[ch].push_back(b);
      pushed[ch]++;
      if (!done) begin
        if (k == MAXB - 1 && !b.last) begin
          b.last = 1'b1;
          b.user = 1'b1;
          exp_aborts++;
        end
        exp_q[ch].push_back(b);
        if (b.last) begin
          done = 1'b1;
          exp_frames[ch]++;
        end
      end
    end
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NCH; i++) if (src_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at negedge, sample 2 units before the next posedge.
  task automatic cycle();
    beat_t o;
    @(negedge clock);
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        consumed[i]++;
        hold[i] = 1'b0;
        acc[i]  = 1'b0;
      end
      if (!hold[i] && src_q[i].size() > 0 && $urandom_range(0, 99) < valid_pct) hold[i] = 1'b1;
      s_tvalid[i] = hold[i] && src_en;
      if (hold[i]) begin
        s_tdata[i*DW +: DW] = src_q[i][0].data;
        s_tkeep[i*KW +: KW] = src_q[i][0].keep;
        s_tlast[i]          = src_q[i][0].last;
        s_tuser[i]          = src_q[i][0].user;
      end else begin
        s_tdata[i*DW +: DW] = $urandom;
        s_tkeep[i*KW +: KW] = 4'($urandom);
        s_tlast[i]          = 1'($urandom);
        s_tuser[i]          = 1'($urandom);
      end
    end
    m_tready = src_en && ($urandom_range(0, 99) < ready_pct);
    #3;
    for (int i = 0; i < NCH; i++) acc[i] = s_tvalid[i] && s_tready[i];
    ready_seen |= s_tready;
    if ($countones(s_tready) > 1) mirror_err++;
    if (m_tvalid && !m_tready && s_tready != '0) mirror_err++;
    if (m_tvalid && m_tready && (s_tready & s_tvalid) == '0) mirror_err++;
    if (m_tvalid && int'(active_channel) != int'(m_tdata[31:24])) active_err++;
    if (m_tvalid && m_tready) begin
      o = {m_tdata, m_tkeep, m_tlast, m_tuser};
      out_q.push_back(o);
      out_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic drain(int budget, output bit timed_out);
    int n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    timed_out = pending();
    repeat (3) cycle();
  endtask

  task automatic do_reset();
    src_en = 1'b0;
    resetn = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < NCH; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      hold[i] = 1'b0;
      acc[i] = 1'b0;
      exp_frames[i] = 0;
      consumed[i] = 0;
      pushed[i] = 0;
    end
    out_q.delete();
    out_cyc.delete();
    exp_aborts = 0;
    mirror_err = 0;
    active_err = 0;
    ready_seen = '0;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    bit to;
    do_reset();
    valid_pct = 100; ready_pct = 100; src_en = 1'b1;
    enqueue_frame(2, 3, 0);
    enqueue_frame(1, 6, 0);
    drain(100, to);
    n_checks++;
    if (abort_count !== 16'd1) begin
      n_fail++; $display("FAIL reset_pre_abort: got %0d expected 1", abort_count);
    end
    do_reset();
    cycle();
    n_checks++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
    n_checks++;
    if (s_tready !== '0) begin n_fail++; $display("FAIL reset_tready: got %b expected 0", s_tready); end
    n_checks++;
    if (abort_count !== 16'd0) begin n_fail++; $display("FAIL reset_abort: got %0d expected 0", abort_count); end
    n_checks++;
    if (frame_count !== '0) begin n_fail++; $display("FAIL reset_frames: got %h expected 0", frame_count); end
    n_checks++;
    if (active_channel !== '0) begin n_fail++; $display("FAIL reset_active: got %0d expected 0", active_channel); end
  endtask

  task automatic test_round_robin();
    bit to;
    do_reset();
    valid_pct = 100; ready_pct = 100; src_en = 1'b1;
    for (int f = 0; f < 4; f++) begin
      enqueue_frame(0, 3, 20);
      enqueue_frame(1, 3, 20);
    end
    drain(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rr_timeout: sources not drained"); end
    n_checks++;
    if (out_q.size() != 24) begin n_fail++; $display("FAIL rr_beats: got %0d expected 24", out_q.size()); end
    for (int j = 0; j < out_q.size() / 3; j++) begin
      n_checks++;
      if (int'(out_q[3*j].data[31:24]) != j % 2) begin
        n_fail++; $display("FAIL rr_order: frame %0d from ch %0d expected ch %0d", j, out_q[3*j].data[31:24], j % 2);
      end
      if (j > 0) begin
        n_checks++;
        if (out_cyc[3*j] - out_cyc[3*j-1] != 2) begin
          n_fail++; $display("FAIL rr_bubble: frame %0d gap %0d expected 2", j, out_cyc[3*j] - out_cyc[3*j-1]);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (frame_count[i*32 +: 32] !== 32'd4) begin
        n_fail++; $display("FAIL rr_frame_count%0d: got %0d expected 4", i, frame_count[i*32 +: 32]);
      end
    end
    n_checks++;
    if (mirror_err != 0) begin n_fail++; $display("FAIL rr_ready_mirror: got %0d errors expected 0", mirror_err); end
  endtask

  task automatic test_abort();
    bit to;
    beat_t o, e;
    do_reset();
    valid_pct = 100; ready_pct = 100; src_en = 1'b1;
    enqueue_frame(0, 6, 0);
    enqueue_frame(0, MAXB, 0);
    drain(200, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL abort_timeout: sources not drained"); end
    n_checks++;
    if (out_q.size() != 8) begin
      n_fail++; $display("FAIL abort_beats: got %0d expected 8", out_q.size());
    end else begin
      n_checks++;
      if ({out_q[3].last, out_q[3].user} !== 2'b11) begin
        n_fail++; $display("FAIL abort_flags: got last/user %b%b expected 11", out_q[3].last, out_q[3].user);
      end
      n_checks++;
      if ({out_q[7].last, out_q[7].user} !== 2'b10) begin
        n_fail++; $display("FAIL full_len_flags: got last/user %b%b expected 10", out_q[7].last, out_q[7].user);
      end
    end
    while (out_q.size() > 0) begin
      o = out_q.pop_front();
      e = exp_q[0].pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL abort_beat: got %h expected %h", o, e); end
    end
    n_checks++;
    if (abort_count !== 16'd1) begin n_fail++; $display("FAIL abort_count: got %0d expected 1", abort_count); end
    n_checks++;
    if (frame_count[31:0] !== 32'd2) begin n_fail++; $display("FAIL abort_frame_count: got %0d expected 2", frame_count[31:0]); end
    n_checks++;
    if (consumed[0] != 10) begin n_fail++; $display("FAIL abort_consumed: got %0d expected 10", consumed[0]); end
  endtask

  task automatic test_priority();
    bit to;
    do_reset();
    valid_pct = 100; ready_pct = 100; src_en = 1'b1;
    enqueue_frame(3, 2, 0);
    drain(100, to);
    out_q.delete();
    enqueue_frame(2, 3, 0);
    enqueue_frame(3, 3, 0);
    drain(100, to);
    n_checks++;
    if (out_q.size() != 6) begin
      n_fail++; $display("FAIL prio_beats: got %0d expected 6", out_q.size());
    end else begin
      n_checks++;
      if (out_q[0].data[31:24] !== 8'd2) begin
        n_fail++; $display("FAIL prio_first: got ch %0d expected ch 2", out_q[0].data[31:24]);
      end
      n_checks++;
      if (out_q[3].data[31:24] !== 8'd3) begin
        n_fail++; $display("FAIL prio_second: got ch %0d expected ch 3", out_q[3].data[31:24]);
      end
    end
    n_checks++;
    if (ready_seen[1:0] !== 2'b00) begin n_fail++; $display("FAIL prio_idle_ready: got %b expected 00", ready_seen[1:0]); end
    n_checks++;
    if (active_err != 0) begin n_fail++; $display("FAIL prio_active: got %0d errors expected 0", active_err); end
  endtask

  task automatic test_random_backpressure();
    bit to;
    beat_t o, e;
    int ch, left;
    do_reset();
    valid_pct = 70; ready_pct = 50; src_en = 1'b1;
    enqueue_frame(1, MAXB, 30);
    enqueue_frame(2, MAXB + 1, 30);
    for (int f = 0; f < 40; f++) enqueue_frame($urandom_range(0, NCH - 1), $urandom_range(1, 7), 15);
    drain(5000, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rand_timeout: sources not drained"); end
    while (out_q.size() > 0) begin
      o = out_q.pop_front();
      ch = int'(o.data[31:24]);
      n_checks++;
      if (ch >= NCH || exp_q[ch].size() == 0) begin
        n_fail++; $display("FAIL rand_beat: got unexpected %h expected none", o);
      end else begin
        e = exp_q[ch].pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rand_beat: got %h expected %h", o, e); end
      end
    end
    left = 0;
    for (int i = 0; i < NCH; i++) left += exp_q[i].size();
    n_checks++;
    if (left != 0) begin n_fail++; $display("FAIL rand_lost: got %0d beats missing expected 0", left); end
    for (int i = 0; i < NCH; i++) begin
      n_checks++;
      if (frame_count[i*32 +: 32] !== 32'(exp_frames[i])) begin
        n_fail++; $display("FAIL rand_frame_count%0d: got %0d expected %0d", i, frame_count[i*32 +: 32], exp_frames[i]);
      end
      n_checks++;
      if (consumed[i] != pushed[i]) begin
        n_fail++; $display("FAIL rand_consumed%0d: got %0d expected %0d", i, consumed[i], pushed[i]);
      end
    end
    n_checks++;
    if (abort_count !== 16'(exp_aborts)) begin
      n_fail++; $display("FAIL rand_abort_count: got %0d expected %0d", abort_count, exp_aborts);
    end
    n_checks++;
    if (mirror_err != 0) begin n_fail++; $display("FAIL rand_ready_mirror: got %0d errors expected 0", mirror_err); end
    n_checks++;
    if (active_err != 0) begin n_fail++; $display("FAIL rand_active: got %0d errors expected 0", active_err); end
  endtask

  task automatic test_reset_midframe();
    bit to;
    beat_t o, e;
    int n, ch;
    do_reset();
    valid_pct = 100; ready_pct = 100; src_en = 1'b1;
    enqueue_frame(1, 5, 0);
    n = 0;
    while (out_q.size() < 2 && n < 50) begin
      cycle();
      n++;
    end
    n_checks++;
    if (out_q.size() < 2) begin n_fail++; $display("FAIL mid_timeout: got %0d beats expected 2", out_q.size()); end
    resetn = 1'b0;
    src_en = 1'b0;
    cycle();
    n_checks++;
    if ({m_tvalid, s_tready} !== '0) begin
      n_fail++; $display("FAIL mid_outputs: got tvalid %b tready %b expected 0", m_tvalid, s_tready);
    end
    n_checks++;
    if (active_channel !== '0) begin n_fail++; $display("FAIL mid_active: got %0d expected 0", active_channel); end
    n_checks++;
    if ({frame_count, abort_count} !== '0) begin
      n_fail++; $display("FAIL mid_counters: got %h %h expected 0", frame_count, abort_count);
    end
    resetn = 1'b1;
    out_q.delete();
    exp_q[1] = src_q[1];
    for (int i = 0; i < NCH; i++) exp_frames[i] = 0;
    exp_frames[1] = 1;
    exp_aborts = 0;
    enqueue_frame(0, 2, 0);
    src_en = 1'b1;
    drain(100, to);
    n_checks++;
    if (out_q.size() != 5) begin
      n_fail++; $display("FAIL mid_beats: got %0d expected 5", out_q.size());
    end else begin
      n_checks++;
      if (out_q[0].data[31:24] !== 8'd0) begin
        n_fail++; $display("FAIL mid_priority: got ch %0d expected ch 0", out_q[0].data[31:24]);
      end
    end
    while (out_q.size() > 0) begin
      o = out_q.pop_front();
      ch = int'(o.data[31:24]);
      n_checks++;
      if (ch >= NCH || exp_q[ch].size() == 0) begin
        n_fail++; $display("FAIL mid_beat: got unexpected %h expected none", o);
      end else begin
        e = exp_q[ch].pop_front();
        if (o !== e) begin n_fail++; $display("FAIL mid_beat: got %h expected %h", o, e); end
      end
    end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (frame_count[i*32 +: 32] !== 32'(exp_frames[i])) begin
        n_fail++; $display("FAIL mid_frame_count%0d: got %0d expected %0d", i, frame_count[i*32 +: 32], exp_frames[i]);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; frame_id = 0;
    resetn = 1'b0; src_en = 1'b0; valid_pct = 0; ready_pct = 0;
    s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0; s_tvalid = '0; m_tready = 1'b0;
    ready_seen = '0; mirror_err = 0; active_err = 0; exp_aborts = 0;
    for (int i = 0; i < NCH; i++) begin
      hold[i] = 1'b0; acc[i] = 1'b0; exp_frames[i] = 0; consumed[i] = 0; pushed[i] = 0;
    end
    test_reset();
    test_round_robin();
    test_abort();
    test_priority();
    test_random_backpressure();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
